// File: rtl/xm23_alu_sequencer.sv
// Execute-stage sequencer for the XM23 register/constant ALU instructions (0x40-0x4B).
// Owns R0-R7 and the PSW, drives an external combinational ALU and writes results back.
module xm23_alu_sequencer #(
  parameter int unsigned NREGS = 8,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   instr,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [3:0]    alu_mode,
  output logic          alu_cin,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_cout,
  output logic          done,
  output logic          err,
  output logic [3:0]    psw_flags,
  input  logic          reg_we,
  input  logic [2:0]    reg_waddr,
  input  logic [DW-1:0] reg_wdata,
  input  logic [2:0]    dbg_raddr,
  output logic [DW-1:0] dbg_rdata
);

  localparam logic [7:0] OP_ADD  = 8'h40;
  localparam logic [7:0] OP_ADDC = 8'h41;
  localparam logic [7:0] OP_SUB  = 8'h42;
  localparam logic [7:0] OP_SUBC = 8'h43;
  localparam logic [7:0] OP_DADD = 8'h44;
  localparam logic [7:0] OP_CMP  = 8'h45;
  localparam logic [7:0] OP_XOR  = 8'h46;
  localparam logic [7:0] OP_AND  = 8'h47;
  localparam logic [7:0] OP_OR   = 8'h48;
  localparam logic [7:0] OP_BIT  = 8'h49;
  localparam logic [7:0] OP_BIC  = 8'h4A;
  localparam logic [7:0] OP_BIS  = 8'h4B;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   rf_q [NREGS];
  logic [DW-1:0]   rf_d [NREGS];
  logic [7:0]      op_q, op_d;
  logic            byte_q, byte_d;
  logic [2:0]      dst_q, dst_d;
  logic [7:0]      dst_hi_q, dst_hi_d;
  logic            a_sign_q, a_sign_d;
  logic            b_sign_q, b_sign_d;
  logic [DW-1:0]   res_q, res_d;
  logic            cout_q, cout_d;
  logic [3:0]      psw_q, psw_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [DW-1:0]   alu_a_q, alu_a_d;
  logic [DW-1:0]   alu_b_q, alu_b_d;
  logic [3:0]      alu_mode_q, alu_mode_d;
  logic            alu_cin_q, alu_cin_d;

  logic [DW-1:0]   dst_val, src_val;
  logic            wr;

  function automatic logic [DW-1:0] con_val(input logic [2:0] k);
    case (k)
      3'd0:    return DW'(0);
      3'd1:    return DW'(1);
      3'd2:    return DW'(2);
      3'd3:    return DW'(4);
      3'd4:    return DW'(8);
      3'd5:    return DW'(16);
      3'd6:    return DW'(32);
      default: return {DW{1'b1}};
    endcase
  endfunction

  // {mode, cin} presented to the ALU for each opcode
  function automatic logic [4:0] alu_ctl(input logic [7:0] op, input logic c);
    case (op)
      OP_ADD:  return {4'b0110, 1'b0};
      OP_ADDC: return {4'b0110, c};
      OP_SUB:  return {4'b0111, 1'b1};
      OP_SUBC: return {4'b0111, c};
      OP_DADD: return {4'b1000, c};
      OP_CMP:  return {4'b0111, 1'b1};
      OP_XOR:  return {4'b0010, 1'b0};
      OP_AND:  return {4'b0000, 1'b0};
      OP_OR:   return {4'b0001, 1'b0};
      OP_BIT:  return {4'b0011, 1'b0};
      OP_BIC:  return {4'b0100, 1'b0};
      OP_BIS:  return {4'b0101, 1'b0};
      default: return 5'b0;
    endcase
  endfunction

  // Flag ingredients, valid in WB from the captured result and latched operand signs
  logic          r_sign, r_zero, c_add, c_sub, v_add, v_sub;
  logic [DW-1:0] wb_val;

  assign r_sign = byte_q ? res_q[7] : res_q[DW-1];
  assign r_zero = byte_q ? (res_q[7:0] == 8'h00) : (res_q == '0);
  assign c_add  = byte_q ? res_q[8] : cout_q;
  assign c_sub  = byte_q ? ~res_q[8] : cout_q;
  assign v_add  = (a_sign_q == b_sign_q) && (r_sign != a_sign_q);
  assign v_sub  = (a_sign_q != b_sign_q) && (r_sign != a_sign_q);
  assign wb_val = byte_q ? {dst_hi_q, res_q[7:0]} : res_q;

  always_comb begin
    state_d    = state_q;
    rf_d       = rf_q;
    op_d       = op_q;
    byte_d     = byte_q;
    dst_d      = dst_q;
    dst_hi_d   = dst_hi_q;
    a_sign_d   = a_sign_q;
    b_sign_d   = b_sign_q;
    res_d      = res_q;
    cout_d     = cout_q;
    psw_d      = psw_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    alu_a_d    = '0;
    alu_b_d    = '0;
    alu_mode_d = '0;
    alu_cin_d  = 1'b0;
    wr         = 1'b0;
    dst_val    = rf_q[instr[2:0]];
    src_val    = instr[7] ? con_val(instr[5:3]) : rf_q[instr[5:3]];

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d                  = instr[15:8];
          byte_d                = instr[6];
          dst_d                 = instr[2:0];
          dst_hi_d              = dst_val[15:8];
          a_sign_d              = instr[6] ? dst_val[7] : dst_val[DW-1];
          b_sign_d              = instr[6] ? src_val[7] : src_val[DW-1];
          alu_a_d               = instr[6] ? DW'(dst_val[7:0]) : dst_val;
          alu_b_d               = instr[6] ? DW'(src_val[7:0]) : src_val;
          {alu_mode_d, alu_cin_d} = alu_ctl(instr[15:8], psw_q[0]);
          state_d               = EXEC;
        end else if (reg_we) begin
          rf_d[reg_waddr] = reg_wdata;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        cout_d  = alu_cout;
        state_d = WB;
      end
      WB: begin
        case (op_q)
          OP_ADD, OP_ADDC: begin psw_d = {v_add, r_sign, r_zero, c_add}; wr = 1'b1; end
          OP_SUB, OP_SUBC: begin psw_d = {v_sub, r_sign, r_zero, c_sub}; wr = 1'b1; end
          OP_CMP:          psw_d = {v_sub, r_sign, r_zero, c_sub};
          OP_DADD:         begin psw_d = {1'b0, r_sign, r_zero, c_add}; wr = 1'b1; end
          OP_XOR, OP_AND, OP_OR, OP_BIC, OP_BIS: begin
            psw_d = {psw_q[3], r_sign, r_zero, psw_q[0]};
            wr    = 1'b1;
          end
          OP_BIT:          psw_d = {psw_q[3], r_sign, r_zero, psw_q[0]};
          default:         err_d = 1'b1;
        endcase
        if (wr) rf_d[dst_q] = wb_val;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
      op_q       <= '0;
      byte_q     <= 1'b0;
      dst_q      <= '0;
      dst_hi_q   <= '0;
      a_sign_q   <= 1'b0;
      b_sign_q   <= 1'b0;
      res_q      <= '0;
      cout_q     <= 1'b0;
      psw_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_mode_q <= '0;
      alu_cin_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rf_q       <= rf_d;
      op_q       <= op_d;
      byte_q     <= byte_d;
      dst_q      <= dst_d;
      dst_hi_q   <= dst_hi_d;
      a_sign_q   <= a_sign_d;
      b_sign_q   <= b_sign_d;
      res_q      <= res_d;
      cout_q     <= cout_d;
      psw_q      <= psw_d;
      done_q     <= done_d;
      err_q      <= err_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_mode_q <= alu_mode_d;
      alu_cin_q  <= alu_cin_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_mode  = alu_mode_q;
  assign alu_cin   = alu_cin_q;
  assign done      = done_q;
  assign err       = err_q;
  assign psw_flags = psw_q;
  assign dbg_rdata = rf_q[dbg_raddr];

endmodule

// File: tb/tb_xm23_alu_sequencer.sv
// Bench for xm23_alu_sequencer: behavioural ALU, arithmetic instruction model and
// per-cycle output comparison, with directed vectors pinned by literal expectations.
module tb_xm23_alu_sequencer;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [15:0] instr;
  logic [15:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_mode;
  logic        alu_cin, alu_cout;
  logic        done, err;
  logic [3:0]  psw_flags;
  logic        reg_we;
  logic [2:0]  reg_waddr, dbg_raddr;
  logic [15:0] reg_wdata, dbg_rdata;

  int n_checks = 0;
  int n_err    = 0;

  xm23_alu_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout), .done(done), .err(err),
    .psw_flags(psw_flags), .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational XM23 ALU stand-in, nibble-wise BCD for DADD
  function automatic logic [16:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] m, input logic ci);
    logic [16:0] r;
    logic [4:0]  s;
    logic        c;
    r = '0;
    case (m)
      4'd0: r = {1'b0, a & b};
      4'd1: r = {1'b0, a | b};
      4'd2: r = {1'b0, a ^ b};
      4'd3: r = {1'b0, a & b};
      4'd4: r = {1'b0, a & ~b};
      4'd5: r = {1'b0, a | b};
      4'd6: r = {1'b0, a} + {1'b0, b} + {16'b0, ci};
      4'd7: r = {1'b0, a} + {1'b0, ~b} + {16'b0, ci};
      4'd8: begin
        c = ci;
        for (int i = 0; i < 4; i++) begin
          s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
          if (s > 5'd9) begin s = s + 5'd6; c = 1'b1; end
          else c = 1'b0;
          r[4*i +: 4] = s[3:0];
        end
        r[16] = c;
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb {alu_cout, alu_result} = alu_fn(alu_a, alu_b, alu_mode, alu_cin);

  function automatic int bcd2dec(input int x);
    int r = 0, sc = 1;
    for (int i = 0; i < 4; i++) begin r += ((x >> (4*i)) & 15) * sc; sc *= 10; end
    return r;
  endfunction

  function automatic int dec2bcd(input int x);
    int r = 0, v = x;
    for (int i = 0; i < 4; i++) begin r |= (v % 10) << (4*i); v /= 10; end
    return r;
  endfunction

  // Architectural outcome of one instruction, from the instruction-set rules
  function automatic void predict(input logic [15:0] w, input logic [15:0] dstv,
      input logic [15:0] srcv, input logic [3:0] pin,
      output logic [15:0] ea, output logic [15:0] eb, output logic [3:0] emode,
      output logic ecin, output logic ewb, output logic [15:0] eval,
      output logic [3:0] epsw, output logic eill);
    int op, mask, half, a, b, nb, cin, full, res, sa, sb, s, lim;
    bit byt, v, cf, n, z;
    int kind; // 0 add, 1 sub, 2 dadd, 3 logic, 4 illegal
    op = int'(w[15:8]); byt = w[6];
    mask = byt ? 'hFF : 'hFFFF; half = byt ? 128 : 32768;
    a = int'(dstv) & mask; b = int'(srcv) & mask;
    ea = 16'(a); eb = 16'(b);
    ewb = 1'b1; eill = 1'b0; cin = 0; emode = 4'd0; kind = 3; res = 0;
    case (op)
      'h40: begin emode = 4'd6; cin = 0;      kind = 0; end
      'h41: begin emode = 4'd6; cin = pin[0]; kind = 0; end
      'h42: begin emode = 4'd7; cin = 1;      kind = 1; end
      'h43: begin emode = 4'd7; cin = pin[0]; kind = 1; end
      'h44: begin emode = 4'd8; cin = pin[0]; kind = 2; end
      'h45: begin emode = 4'd7; cin = 1;      kind = 1; ewb = 1'b0; end
      'h46: begin emode = 4'd2; res = a ^ b; end
      'h47: begin emode = 4'd0; res = a & b; end
      'h48: begin emode = 4'd1; res = a | b; end
      'h49: begin emode = 4'd3; res = a & b; ewb = 1'b0; end
      'h4A: begin emode = 4'd4; res = a & ~b & mask; end
      'h4B: begin emode = 4'd5; res = a | b; end
      default: begin kind = 4; ewb = 1'b0; eill = 1'b1; end
    endcase
    ecin = cin[0];
    v = pin[3]; cf = pin[0];
    if (kind == 0 || kind == 1) begin
      nb = (kind == 1) ? (~b & mask) : b;
      full = a + nb + cin;
      res = full & mask; cf = (full > mask);
      sa = (a >= half) ? a - 2*half : a;
      sb = (nb >= half) ? nb - 2*half : nb;
      s = sa + sb + cin;
      v = (s >= half) || (s < -half);
    end else if (kind == 2) begin
      lim = byt ? 100 : 10000;
      s = bcd2dec(a) + bcd2dec(b) + cin;
      cf = (s >= lim); res = dec2bcd(s % lim); v = 1'b0;
    end
    n = (res & half) != 0; z = (res == 0);
    epsw = (kind == 4) ? pin : {v, n, z, cf};
    eval = byt ? {dstv[15:8], 8'(res)} : 16'(res);
  endfunction

  int          m_phase;
  logic [15:0] m_rf [8];
  logic [3:0]  m_psw;
  logic [15:0] p_a, p_b, p_val;
  logic [3:0]  p_mode, p_psw;
  logic        p_cin, p_wb, p_ill;
  logic [2:0]  p_dst;

  // Model advances on each clock edge: 1=operands on ALU, 2=writeback pending, 3=retired
  initial begin
    m_phase = 0; m_psw = '0; p_ill = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_phase = 0; m_psw = '0; p_ill = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2) begin
        if (p_wb) m_rf[p_dst] = p_val;
        m_psw = p_psw; m_phase = 3;
      end else if (in_valid) begin
        predict(instr, m_rf[instr[2:0]],
                instr[7] ? ((instr[5:3] == 3'd7) ? 16'hFFFF
                            : ((instr[5:3] == 3'd0) ? 16'h0000 : 16'(1 << (instr[5:3] - 3'd1))))
                         : m_rf[instr[5:3]],
                m_psw, p_a, p_b, p_mode, p_cin, p_wb, p_val, p_psw, p_ill);
        p_dst = instr[2:0];
        m_phase = 1;
      end else begin
        if (reg_we) m_rf[reg_waddr] = reg_wdata;
        m_phase = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("in_ready", 32'(in_ready), 32'(m_phase == 0 || m_phase == 3));
        chk("done", 32'(done), 32'(m_phase == 3));
        chk("err", 32'(err), 32'(m_phase == 3 && p_ill));
        chk("psw", 32'(psw_flags), 32'(m_psw));
        chk("dbg_rdata", 32'(dbg_rdata), 32'(m_rf[dbg_raddr]));
        if (m_phase == 1 && !p_ill) begin
          chk("alu_a", 32'(alu_a), 32'(p_a));
          chk("alu_b", 32'(alu_b), 32'(p_b));
          chk("alu_mode", 32'(alu_mode), 32'(p_mode));
          chk("alu_cin", 32'(alu_cin), 32'(p_cin));
        end else if (m_phase != 1) begin
          chk("alu_idle", 32'({alu_a, alu_b, alu_mode, alu_cin}), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic load(input logic [2:0] r, input logic [15:0] d);
    reg_we = 1'b1; reg_waddr = r; reg_wdata = d;
    @(posedge clk); #2;
    reg_we = 1'b0;
  endtask

  task automatic issue(input logic [15:0] w);
    int n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #2; n++; end
    if (n >= 20) chk("issue_ready_timeout", 32'(in_ready), 32'd1);
    instr = w; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  task automatic retire();
    @(posedge clk); @(posedge clk); #3;
  endtask

  task automatic peek(input string nm, input logic [2:0] r, input logic [15:0] exp);
    dbg_raddr = r; #1;
    chk(nm, 32'(dbg_rdata), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; instr = '0; reg_we = 1'b0;
    reg_waddr = '0; reg_wdata = '0; dbg_raddr = '0;
    repeat (2) @(posedge clk); #2;
    chk("rst_alu", 32'({alu_a, alu_b, alu_mode, alu_cin}), 32'd0);
    chk("rst_psw", 32'(psw_flags), 32'd0);
    chk("rst_done", 32'({done, err}), 32'd0);
    peek("rst_r0", 3'd0, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2;

    load(3'd1, 16'h7FFF); load(3'd2, 16'h0001); load(3'd3, 16'h0001);
    load(3'd4, 16'h12FF); load(3'd5, 16'h0999); load(3'd6, 16'h0001);

    issue(16'h4011);                       // ADD R2,R1
    #1 chk("t1_alu_a", 32'(alu_a), 32'h7FFF);
    retire();
    chk("t1_done", 32'(done), 32'd1);
    peek("t1_r1", 3'd1, 16'h8000);
    chk("t1_psw", 32'(psw_flags), 32'hC);

    issue(16'h458B);                       // CMP #1,R3
    #1 chk("t2_mode_cin", 32'({alu_mode, alu_cin}), 32'b01111);
    retire();
    peek("t2_r3", 3'd3, 16'h0001);
    chk("t2_psw", 32'(psw_flags), 32'h3);

    issue(16'h40CC);                       // ADD.B #1,R4
    retire();
    peek("t3_r4", 3'd4, 16'h1200);
    chk("t3_psw", 32'(psw_flags), 32'h3);

    issue(16'h4080);                       // ADD #0,R0 clears C
    retire();
    chk("clrc_psw", 32'(psw_flags), 32'h2);

    issue(16'h442E);                       // DADD R5,R6
    retire();
    peek("t4_r6", 3'd6, 16'h1000);
    chk("t4_psw", 32'(psw_flags), 32'h0);

    issue(16'h3000);                       // illegal
    retire();
    chk("t5_done_err", 32'({done, err}), 32'b11);
    chk("t5_psw", 32'(psw_flags), 32'h0);
    peek("t5_r6", 3'd6, 16'h1000);
    @(posedge clk); #3;
    chk("t5_in_ready", 32'(in_ready), 32'd1);

    // External load offered with an instruction and while busy must be ignored
    reg_we = 1'b1; reg_waddr = 3'd7; reg_wdata = 16'hBEEF;
    issue(16'h4212);                       // SUB R2,R2
    retire();
    reg_we = 1'b0;
    peek("we_ignored_r7", 3'd7, 16'h0000);
    peek("sub_same_r2", 3'd2, 16'h0000);
    chk("sub_same_psw", 32'(psw_flags), 32'h3);

    issue(16'h4BFC);                       // BIS.B #0xFFFF,R4
    retire();
    peek("bisb_r4", 3'd4, 16'h12FF);
    chk("bisb_psw", 32'(psw_flags), 32'h5);

    issue(16'h4311);                       // SUBC R2,R1
    issue(16'h4911);                       // BIT R2,R1
    issue(16'h4865);                       // OR.B R4,R5
    retire();
    peek("burst_r1", 3'd1, 16'h8000);
    peek("burst_r5", 3'd5, 16'h09FF);
    chk("burst_psw", 32'(psw_flags), 32'h5);

    for (int r = 0; r < 8; r++) peek("final_rf", 3'(r), m_rf[r]);

    // Reset in the middle of an ADD discards it
    load(3'd1, 16'h7FFF); load(3'd2, 16'h0001);
    issue(16'h4011);
    #1 rst = 1'b1;
    #1;
    chk("t6_alu", 32'({alu_a, alu_b, alu_mode, alu_cin}), 32'd0);
    chk("t6_done_err", 32'({done, err}), 32'd0);
    chk("t6_psw", 32'(psw_flags), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    peek("t6_r1", 3'd1, 16'h0000);
    repeat (4) @(negedge clk);
    chk("t6_no_done", 32'(done), 32'd0);
    peek("t6_r1_late", 3'd1, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
